// File: rtl/downsample_engine.sv
// 2x2 rounding box-filter downsampler: streams the source image out of the image RAM in
// block order (TL, TR, BL, BR) and writes one averaged pixel per block to the result RAM.
module downsample_engine #(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int ADDR_W     = 16,
    parameter int OUT_ADDR_W = 14,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [7:0]            rd_data,
    output logic                  wr_en,
    output logic [OUT_ADDR_W-1:0] wr_addr,
    output logic [7:0]            wr_data
);

    localparam int OUT_W = IMG_W / 2;
    localparam int OUT_H = IMG_H / 2;
    localparam logic [ADDR_W-1:0] LAST_OX = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] LAST_OY = ADDR_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] ROW     = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic [ADDR_W-1:0]       rd_addr_reg;
    logic [1:0]              phase_reg;
    logic [ADDR_W-1:0]       ox_reg;
    logic [ADDR_W-1:0]       oy_reg;

    logic [1:0]              phase_next;
    logic [ADDR_W-1:0]       ox_next;
    logic [ADDR_W-1:0]       oy_next;
    logic [ADDR_W-1:0]       addr_next;
    logic                    last_read;

    logic [RD_LAT-1:0]       pipe_valid;
    logic                    cons_valid;
    logic                    cons_first;
    logic                    cons_last;

    logic [9:0]              acc_reg;
    logic [9:0]              sum_next;
    logic [9:0]              rounded;
    logic                    wr_en_reg;
    logic [OUT_ADDR_W-1:0]   wr_addr_reg;
    logic [7:0]              wr_data_reg;
    logic [OUT_ADDR_W-1:0]   out_idx_reg;

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rd_addr = rd_addr_reg;
    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;

    // Source address of one sample: phase bit 0 selects the right column, bit 1 the lower row.
    function automatic logic [ADDR_W-1:0] src_addr(
        input logic [ADDR_W-1:0] ox,
        input logic [ADDR_W-1:0] oy,
        input logic [1:0]        ph
    );
        logic [ADDR_W-1:0] tl;
        tl = ((oy << 1) * ROW) + (ox << 1);
        return tl + (ph[1] ? ROW : '0) + (ph[0] ? ONE : '0);
    endfunction

    always_comb begin
        phase_next = phase_reg + 2'd1;
        ox_next    = ox_reg;
        oy_next    = oy_reg;
        if (phase_reg == 2'd3) begin
            if (ox_reg == LAST_OX) begin
                ox_next = '0;
                oy_next = oy_reg + ONE;
            end else begin
                ox_next = ox_reg + ONE;
            end
        end
        last_read = (phase_reg == 2'd3) && (ox_reg == LAST_OX) && (oy_reg == LAST_OY);
        addr_next = src_addr(ox_next, oy_next, phase_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            rd_addr_reg <= '0;
            phase_reg   <= 2'd0;
            ox_reg      <= '0;
            oy_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= READ;
                        busy_reg    <= 1'b1;
                        rd_addr_reg <= '0;
                        phase_reg   <= 2'd0;
                        ox_reg      <= '0;
                        oy_reg      <= '0;
                    end
                end
                READ: begin
                    if (last_read) begin
                        state_reg <= DRAIN;
                    end else begin
                        phase_reg   <= phase_next;
                        ox_reg      <= ox_next;
                        oy_reg      <= oy_next;
                        rd_addr_reg <= addr_next;
                    end
                end
                DRAIN: begin
                    // Pipeline empties in the cycle the final write is presented.
                    if (pipe_valid == '0) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Read-return tracker: one stage per cycle of RAM latency, tagged at issue time.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            logic valid_reg;
            logic first_reg;
            logic last_reg;
            logic valid_in;
            logic first_in;
            logic last_in;

            if (gi == 0) begin : g_head
                assign valid_in = (state_reg == READ);
                assign first_in = (phase_reg == 2'd0);
                assign last_in  = (phase_reg == 2'd3);
            end else begin : g_tail
                assign valid_in = g_pipe[gi-1].valid_reg;
                assign first_in = g_pipe[gi-1].first_reg;
                assign last_in  = g_pipe[gi-1].last_reg;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    first_reg <= 1'b0;
                    last_reg  <= 1'b0;
                end else begin
                    valid_reg <= valid_in;
                    first_reg <= first_in;
                    last_reg  <= last_in;
                end
            end

            assign pipe_valid[gi] = valid_reg;
        end
    endgenerate

    assign cons_valid = g_pipe[RD_LAT-1].valid_reg;
    assign cons_first = g_pipe[RD_LAT-1].first_reg;
    assign cons_last  = g_pipe[RD_LAT-1].last_reg;

    always_comb begin
        sum_next = (cons_first ? 10'd0 : acc_reg) + {2'b00, rd_data};
        rounded  = sum_next + 10'd2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg     <= 10'd0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= 8'd0;
            out_idx_reg <= '0;
        end else begin
            wr_en_reg <= 1'b0;
            if ((state_reg == IDLE) && start) begin
                wr_addr_reg <= '0;
                out_idx_reg <= '0;
            end
            if (cons_valid) begin
                acc_reg <= sum_next;
                if (cons_last) begin
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= out_idx_reg;
                    wr_data_reg <= rounded[9:2];
                    out_idx_reg <= out_idx_reg + OUT_ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/downsample_engine.md
# downsample_engine

2x2 box-filter downsampler placed directly downstream of the UART loader. Once the loader signals that the full source image is in the image RAM, this block reads the image through the RAM's external address/data port. It averages each 2x2 pixel block with rounding and writes one 8-bit pixel per block to the result RAM. The UART retrieve path then sends the result RAM back to the host.

## Interface
- IMG_W, 256: source width in pixels; power of two, >= 2
- IMG_H, 256: source height in pixels; power of two, >= 2
- ADDR_W, 16: source address width; IMG_W*IMG_H <= 2^ADDR_W
- OUT_ADDR_W, 14: result address width; (IMG_W/2)*(IMG_H/2) <= 2^OUT_ADDR_W
- RD_LAT, 2: source RAM read latency in cycles, >= 1

- clk  in  1  system clock (PLL output); all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle start request; normally driven by the loader's write_done
- busy  out  1  high from the first read cycle through the done cycle
- done  out  1  one-cycle pulse when the last result pixel has been written
- rd_addr  out  ADDR_W  source RAM address (registered)
- rd_data  in  8  source RAM read data, valid RD_LAT cycles after rd_addr
- wr_en  out  1  result RAM write strobe (registered)
- wr_addr  out  OUT_ADDR_W  result RAM address (registered)
- wr_data  out  8  result pixel (registered)

## Operation
- Reset: state IDLE. busy, done, wr_en = 0. rd_addr, wr_addr, wr_data = 0. All counters and the accumulator = 0. Reset asserted mid-frame aborts the frame; no further wr_en after reset; no done.
- States:
  - IDLE: on start=1, go to READ. rd_addr is loaded with the first address.
  - READ: issue one read address per cycle, 4*N reads total, where N = (IMG_W/2)*(IMG_H/2). After the last read, go to DRAIN.
  - DRAIN: wait for the in-flight data to return and the last write to finish, then go to DONE.
  - DONE: pulse done for one cycle, then go to IDLE.
- start is ignored in READ, DRAIN and DONE. It may be held high; a new frame starts only on start=1 in IDLE, so a held start re-triggers once back in IDLE.
- Read order: raster over output pixels (oy outer, ox inner). For each output pixel, four reads in order TL, TR, BL, BR:
  - TL = (2oy)*IMG_W + 2ox
  - TR = TL + 1
  - BL = TL + IMG_W
  - BR = TL + IMG_W + 1
- Returned-data tracking: a RD_LAT-deep valid/last-of-group shift register, keyed to the issue cycle. It does not depend on rd_data content.
- Arithmetic:
  - 10-bit accumulator. The first sample of each group loads it; the next three add to it.
  - wr_data = (sum + 2) >> 2, truncated to 8 bits. The maximum result is (1020+2)>>2 = 255, so the output never overflows.
- wr_addr = output pixel index oy*(IMG_W/2)+ox. It runs sequentially from 0 to N-1 and returns to 0 when the next frame starts.

## Timing
- Cycle numbering:
  - Edge 0: start is sampled in IDLE.
  - Cycle k (k = 0..4N-1): the cycle after edge k. In cycle k, rd_addr holds read k and busy=1.
- rd_data for read k is sampled at the end of cycle k+RD_LAT.
- wr_en for output j is high for exactly one cycle, cycle 4j+3+RD_LAT+1, with matching wr_addr=j and wr_data. Writes occur at most one every 4 cycles.
- Last write is in cycle 4N+RD_LAT. done=1 in cycle 4N+RD_LAT+1. busy falls to 0 in the following cycle, together with the return to IDLE.
- Default parameters (256x256): N=16384, last rd_addr 0xFFFF in cycle 65535, last write in cycle 65538, done in cycle 65539.
- rd_addr holds its last value in DRAIN, DONE and IDLE.

## Test plan
- IMG_W=8, IMG_H=4, RD_LAT=2, source pixel[a] = a: pulse start, then check:
  - rd_addr sequence begins 0,1,8,9,2,3,10,11.
  - First write in cycle 6: wr_addr=0, wr_data=(0+1+8+9+2)>>2=5.
  - 8 writes total, wr_addr 0..7.
  - done in cycle 35.
- Rounding at default size: blocks (0,0,0,1) -> 0; (0,0,0,2) -> 1; (1,2,3,4) -> 3; (255,255,255,255) -> 255.
- Start asserted during READ at cycle 10, and start held high for 5 cycles: rd_addr sequence unchanged; exactly one done per frame.
- RD_LAT=1 and RD_LAT=4 with the 8x4 ramp image: same wr_data/wr_addr sequence as the first scenario; first write in cycle 3+RD_LAT+1.
- Reset asserted in cycle 20 of the 8x4 frame:
  - Outputs are 0 immediately, asynchronously.
  - No wr_en and no done afterward.
  - A new start after reset produces the full correct frame from wr_addr 0.
- Back-to-back frames: start pulsed in the IDLE cycle after done; the second frame is identical to the first and wr_addr restarts at 0.
